dds_sweep_ctrl: RTL
===================

// Module: dds_sweep_ctrl
// PURPOSE
//   Frequency-sweep controller sitting directly upstream of the DDS phase-accumulator core.
//   It drives that core's 12-bit tuning word M.
//   Steps M linearly from a start word to a stop word, holding each word for a programmable dwell.
//   Supports single-shot or continuous (repeating sawtooth) sweeps.
//   Start/abort control with busy/done/wrap status for the test sequencer.
// PARAMETERS
//   W       12  tuning-word width; m_out feeds the DDS M input directly
//   DWELL_W 16  dwell-counter width
// PORTS
//   clk      in   1        system clock (200 MHz DDS clock)
//   rst      in   1        asynchronous, active-low reset
//   start    in   1        1-cycle request to begin a sweep; honoured only in IDLE
//   abort    in   1        synchronous stop; honoured in RUN and DONE
//   mode     in   1        0 = single-shot, 1 = continuous; captured with start
//   m_start  in   W        first tuning word; captured with start
//   m_stop   in   W        last tuning word; captured with start
//   m_step   in   W        step magnitude, unsigned; captured with start
//   dwell    in   DWELL_W  clocks per word; 0 is treated as 1; captured with start
//   m_out    out  W        tuning word to the DDS core (registered)
//   busy     out  1        high while in RUN
//   done     out  1        1-cycle pulse when a single-shot sweep completes
//   wrap     out  1        1-cycle pulse when a continuous sweep restarts at m_start
// BEHAVIOUR
//   Reset (rst low, asynchronous): state=IDLE, m_out=0, busy=0, done=0, wrap=0, shadow regs=0, dwell cnt=0.
//   States: IDLE -> RUN -> DONE -> IDLE. All outputs are registered; no combinational paths from inputs.
//   IDLE
//     - m_out holds its last value. busy=0.
//     - On start (and abort low), capture all config into shadow regs, go to RUN, m_out<=m_start.
//     - m_start is visible on m_out the cycle after start is sampled.
//     - Config inputs are ignored outside this capture edge.
//   RUN
//     - Each m_out value is held for exactly max(dwell,1) cycles.
//     - Direction is up if m_stop >= m_start, else down.
//     - Next word = m_out +/- m_step, computed in W+1 bits.
//     - If the next word would reach or pass m_stop (including over/underflow past 0 or 2^W-1), it saturates to m_stop.
//     - m_out never wraps modulo 2^W.
//     - m_step==0, or m_start==m_stop: a single dwell at m_start, then the sweep ends.
//     - End of sweep = dwell expiry while m_out==m_stop.
//       - mode=0: go to DONE.
//       - mode=1: m_out<=m_start, wrap=1 for that one cycle, stay in RUN, repeat indefinitely.
//   DONE
//     - One cycle: done=1, busy=0, m_out holds m_stop. Then IDLE.
//     - start in DONE is ignored; the sequencer must wait for IDLE.
//   abort
//     - In RUN or DONE: next state IDLE, m_out<=0 (silences the DDS), busy=0.
//     - No done or wrap pulse is produced.
//     - In IDLE, abort has no effect except that it blocks a same-cycle start (abort wins).
//   Reset mid-sweep: asynchronous return to the reset values above; shadow config is lost.
//   Total busy cycles for single-shot = (number of distinct words) * max(dwell,1).
// TESTING
//   1 Up sweep: m_start=10, m_stop=40, m_step=10, dwell=3, mode=0, start pulse.
//     -> m_out = 10,10,10,20,20,20,30,30,30,40,40,40 with busy=1 for 12 cycles.
//     -> Then done=1 for 1 cycle, m_out stays 40, back to IDLE.
//   2 Down sweep with saturation: m_start=100, m_stop=75, m_step=10, dwell=1.
//     -> m_out = 100,90,80,75; done on cycle 5.
//     Edge: m_start=4090, m_stop=4095, m_step=10, dwell=2 -> 4090,4090,4095,4095; no wrap to low values.
//   3 Continuous: mode=1, m_start=0, m_stop=64, m_step=32, dwell=2.
//     -> 0,0,32,32,64,64,0,... with wrap=1 exactly on each return to 0.
//     -> done never asserts; busy stays 1.
//   4 Abort: abort on the 5th busy cycle of scenario 1.
//     -> Next cycle: m_out=0, busy=0, IDLE, no done.
//     -> Simultaneous start+abort in IDLE: no sweep, m_out unchanged.
//   5 Degenerate configs:
//     - dwell=0, m_start=m_stop=7 -> m_out=7 for 1 cycle, then done.
//     - m_step=0, m_start=5, m_stop=9 -> m_out=5 for one dwell, then done.
//     - start while busy -> ignored, sweep unaffected.
//   6 Async reset: drive rst low mid-dwell, between clock edges.
//     -> m_out=0, busy=0 immediately without a clock edge.
//     -> After rst release, a fresh start runs normally.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving the tuning word M of a DDS phase-accumulator core.
// Steps M from a start word to a stop word with a programmable dwell, single-shot or continuous.
module dds_sweep_ctrl #(
    parameter int W       = 12,
    parameter int DWELL_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               mode_i,
    input  logic [W-1:0]       m_start_i,
    input  logic [W-1:0]       m_stop_i,
    input  logic [W-1:0]       m_step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [W-1:0]       m_out_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               wrap_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [W-1:0]       m_q, m_d;
    logic               mode_q, mode_d;
    logic               up_q, up_d;
    logic [W-1:0]       start_q, start_d;
    logic [W-1:0]       stop_q, stop_d;
    logic [W-1:0]       step_q, step_d;
    logic [DWELL_W-1:0] reload_q, reload_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;

    logic [W:0]         sum_w;
    logic [W:0]         diff_w;
    logic [W-1:0]       next_word;
    logic               sweep_end;
    logic [DWELL_W-1:0] dwell_reload;

    // Dwell counter counts down from max(dwell,1)-1, so a dwell of 0 behaves as 1.
    always_comb begin
        dwell_reload = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
    end

    // Next word is formed one bit wider so over/underflow saturates to the stop word instead of wrapping.
    always_comb begin
        sum_w  = {1'b0, m_q} + {1'b0, step_q};
        diff_w = {1'b0, m_q} - {1'b0, step_q};
        if (up_q) begin
            next_word = (sum_w >= {1'b0, stop_q}) ? stop_q : sum_w[W-1:0];
        end else begin
            next_word = (diff_w[W] || (diff_w[W-1:0] <= stop_q)) ? stop_q : diff_w[W-1:0];
        end
        sweep_end = (m_q == stop_q) || (step_q == '0);
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        mode_d   = mode_q;
        up_d     = up_q;
        start_d  = start_q;
        stop_d   = stop_q;
        step_d   = step_q;
        reload_d = reload_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_i && !abort_i) begin
                    state_d  = ST_RUN;
                    mode_d   = mode_i;
                    start_d  = m_start_i;
                    stop_d   = m_stop_i;
                    step_d   = m_step_i;
                    reload_d = dwell_reload;
                    up_d     = (m_stop_i >= m_start_i);
                    cnt_d    = dwell_reload;
                    m_d      = m_start_i;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    m_d     = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (sweep_end) begin
                    if (mode_q) begin
                        m_d    = start_q;
                        wrap_d = 1'b1;
                        cnt_d  = reload_q;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    m_d   = next_word;
                    cnt_d = reload_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (abort_i) begin
                    m_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            m_q      <= '0;
            mode_q   <= 1'b0;
            up_q     <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            reload_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            mode_q   <= mode_d;
            up_q     <= up_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign m_out_o = m_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign wrap_o  = wrap_q;

endmodule
